// File: rtl/dmem_ctrl_pkg.sv
// Shared types and defaults for the data-memory access controller.
// Optional feature macro: DMEM_TIMEOUT_EN (BUSY-cycle watchdog with sticky error).
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  // Default watchdog limit in BUSY cycles
  localparam int unsigned DMEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Saturating BUSY-cycle counter. expired_o flags the enabled cycle whose
// increment brings the count to LIMIT, so the owner can abort in that cycle.
module dmem_timeout_cnt #(
  parameter int unsigned LIMIT = 16,
  parameter int unsigned W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [W-1:0] CNT_MAX  = W'(LIMIT);
  localparam logic [W-1:0] CNT_LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and hold at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (en_i && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = en_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle MEM-stage data-memory controller with req/ack handshake.
// Latches one load/store, holds dm_req until dm_ack, stalls the PC meanwhile.
// Optional feature macro: DMEM_TIMEOUT_EN aborts an access after TIMEOUT BUSY
// cycles without ack and raises sticky dm_err; otherwise BUSY waits forever.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int N       = 64,
  parameter int TIMEOUT = DMEM_TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memRead,
  input  logic         memWrite,
  input  logic [N-1:0] address,
  input  logic [N-1:0] writeData,
  output logic [N-1:0] dataReadDM,
  output logic         PC_enable,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic [N-1:0] dm_rdata,
  input  logic         dm_ack,
  output logic         dm_err
);

  // A zero limit would make every access abort before it starts
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("dmem_access_ctrl: TIMEOUT must be >= 1");
  end

  dmem_state_e  state_q, state_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [N-1:0] rdata_q, rdata_d;
  logic         we_q, we_d;
  logic         req_q, req_d;
  logic         err_q, err_d;
  logic         timeout;

`ifdef DMEM_TIMEOUT_EN
  // Counter is held clear outside BUSY, so it starts at 0 on BUSY entry
  dmem_timeout_cnt #(
    .LIMIT(TIMEOUT)
  ) u_timeout_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_q != BUSY),
    .en_i     ((state_q == BUSY) && !dm_ack),
    .expired_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Next-state and datapath latch logic for the IDLE/BUSY/DONE handshake
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (memRead || memWrite) begin
          addr_d  = address;
          wdata_d = writeData;
          we_d    = memWrite;       // read+write together is a write
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (dm_ack) begin           // ack beats a simultaneous timeout
          if (!we_q) rdata_d = dm_rdata;
          state_d = DONE;
        end else if (timeout) begin
          err_d = 1'b1;
          if (!we_q) rdata_d = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;      // requests seen here belong to the finished instruction
      default: state_d = IDLE;
    endcase
    req_d = (state_d == BUSY);
  end

  // All controller state, cleared by synchronous reset even mid-access
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  assign PC_enable  = (state_q == DONE) || ((state_q == IDLE) && !memRead && !memWrite);
  assign dm_req     = req_q;
  assign dm_we      = we_q;
  assign dm_addr    = addr_q;
  assign dm_wdata   = wdata_q;
  assign dataReadDM = rdata_q;
  assign dm_err     = err_q;

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Multi-cycle data-memory access controller between the MEM stage and an external data memory with a req/ack handshake. It latches each load/store and drives the memory request until acknowledged. It returns load data as `dataReadDM` and holds `PC_enable` low for the whole access. It sits directly upstream of `memoryStall`, and its outputs replace that block's constant `PC_enable`.

## Interface
- `N`, 64, data and address width
- `TIMEOUT`, 16, maximum BUSY cycles before abort; used only with `DMEM_TIMEOUT_EN`, must be ≥1
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low; sampled on rising `clk`
- `memRead`  in  1  MEM-stage load request
- `memWrite`  in  1  MEM-stage store request
- `address`  in  N  byte address from ALU
- `writeData`  in  N  store data
- `dataReadDM`  out  N  registered load data; held until the next load completes
- `PC_enable`  out  1  1 = pipeline may advance; 0 = stall
- `dm_req`  out  1  memory request, held until `dm_ack`
- `dm_we`  out  1  1 = write, 0 = read; valid while `dm_req`
- `dm_addr`  out  N  latched address; valid while `dm_req`
- `dm_wdata`  out  N  latched store data; valid while `dm_req`
- `dm_rdata`  in  N  memory read data; valid in the `dm_ack` cycle
- `dm_ack`  in  1  one-cycle completion strobe from memory
- `dm_err`  out  1  sticky timeout flag; constant 0 without `DMEM_TIMEOUT_EN`

## Operation
FSM states: IDLE, BUSY, DONE.

**IDLE**
- `memRead|memWrite` = 1: latch `address`, `writeData`, and `dm_we = memWrite`, then go to BUSY.
- Otherwise stay in IDLE.

**BUSY**
- `dm_req` = 1; latched fields stay stable.
- `dm_ack` = 1 on a read: capture `dm_rdata` into `dataReadDM`, go to DONE.
- `dm_ack` = 1 on a write: `dataReadDM` unchanged, go to DONE.

**DONE**
- One cycle only, then unconditionally to IDLE.
- Requests present in DONE are ignored; this prevents re-triggering on the instruction that just completed.

**PC_enable**
- Combinational: `(state==DONE) | (state==IDLE & ~memRead & ~memWrite)`.

**Corner cases**
- `memRead` and `memWrite` both high: treated as a write; `dataReadDM` is not updated.
- `dm_ack` in IDLE or DONE: ignored.
- `dm_rdata` outside the ack cycle: ignored.
- No address/width arithmetic; `dm_addr` = latched `address` verbatim.

**Reset** (`reset`=0 at a rising edge, including mid-access)
- Next state IDLE; `dataReadDM`=0; latched fields 0; `dm_err`=0; timeout counter 0.
- From the following cycle: `dm_req`=0 and `dm_we`=0.
- `PC_enable` then follows the IDLE equation.

## Timing
- Request sampled at edge E0 → BUSY from cycle 1, `dm_req` high from cycle 1.
- `dm_ack` in BUSY cycle k (k≥1) → DONE in cycle k+1. In that cycle `dataReadDM` is valid and `PC_enable`=1.
- Minimum occupancy is 3 cycles per memory instruction (ack in the first BUSY cycle).
- `dm_req` falls the cycle after `dm_ack`.
- Non-memory instructions: `PC_enable`=1 every cycle, zero added latency.
- `dataReadDM` changes only on a read ack or reset.

## Configuration
`DMEM_TIMEOUT_EN`

**Defined**
- Counter of width `$clog2(TIMEOUT+1)`: clears on BUSY entry and increments each BUSY cycle without ack.
- When the count reaches `TIMEOUT` with no ack:
  - set `dm_err` (sticky until reset);
  - go to DONE with `dataReadDM` forced to 0 if the access was a read.
- An ack in the same cycle as the limit wins: normal completion, no error.

**Undefined**
- No counter; BUSY waits indefinitely; `dm_err` tied 0.

## Structure
- Package `dmem_ctrl_pkg`: `dmem_state_e` enum {IDLE, BUSY, DONE} and the default `TIMEOUT`.
- Sub-module `dmem_timeout_cnt`: parameterized saturating counter with clear/enable and `expired` output, instantiated only under `DMEM_TIMEOUT_EN`.
- The FSM and data/latch registers stay in the top module.

## Test plan
- Reset: hold `reset`=0 2 cycles with `memRead`=1 → `dm_req`=0, `dataReadDM`=0, `dm_err`=0; after release, IDLE with `PC_enable`=0 while `memRead`=1.
- Load, 1-cycle ack: `memRead`=1, `address`=0x100 at E0; `dm_ack`=1, `dm_rdata`=0xDEADBEEF_CAFEF00D in cycle 1 → cycle 2 `dataReadDM` matches, `PC_enable` = 0,0,1 over cycles 0–2.
- Store with 4-cycle memory delay: `memWrite`=1, `writeData`=0x55, `address`=0x8 → `dm_req`/`dm_we`=1 and `dm_wdata`=0x55 stable cycles 1–4; `dataReadDM` unchanged; `PC_enable` high in cycle 5 only.
- Back-to-back loads, `memRead` held high across both → exactly two `dm_req` bursts separated by the DONE and IDLE cycles; no extra request.
- Reset asserted in the third BUSY cycle → next cycle `dm_req`=0, state IDLE, `dataReadDM`=0; a late `dm_ack` is ignored.
- With `DMEM_TIMEOUT_EN`, `TIMEOUT`=4, no ack → after 4 BUSY cycles go to DONE, `dm_err`=1 sticky, `dataReadDM`=0; without the macro `dm_req` stays high for 100 cycles.
